wb_regfile: RTL

//  Write-back end of the MEM/WB pipeline interface: consumes the registered W-stage

---
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile.sv | 84 ++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// W-stage commit fields in, decode read data and forwarding/count status out.
interface wb_regfile_if #(
    parameter int unsigned RD_Data_Width = 32,
    parameter int unsigned PC_Width      = 32,
    parameter int unsigned Address_Width = 5,
    parameter int unsigned Count_Width   = 32
) ();
    logic                     i_RegWrite_W;
    logic [1:0]               i_ResultSec_W;
    logic [RD_Data_Width-1:0] i_ALU_Res_W;
    logic [RD_Data_Width-1:0] i_ReadData_W;
    logic [PC_Width-1:0]      i_PCPluse4_W;
    logic [PC_Width-1:0]      i_PC_target_W;
    logic [Address_Width-1:0] i_Rd_W;
    logic [Address_Width-1:0] i_A1_D;
    logic [Address_Width-1:0] i_A2_D;
    logic [RD_Data_Width-1:0] o_RD1_D;
    logic [RD_Data_Width-1:0] o_RD2_D;
    logic [RD_Data_Width-1:0] o_Result_W;
    logic [Count_Width-1:0]   o_WB_Count;

    // Pipeline side: drives the W-stage fields and read indices.
    modport master (
        output i_RegWrite_W, i_ResultSec_W, i_ALU_Res_W, i_ReadData_W,
               i_PCPluse4_W, i_PC_target_W, i_Rd_W, i_A1_D, i_A2_D,
        input  o_RD1_D, o_RD2_D, o_Result_W, o_WB_Count
    );

    // Register file side.
    modport slave (
        input  i_RegWrite_W, i_ResultSec_W, i_ALU_Res_W, i_ReadData_W,
               i_PCPluse4_W, i_PC_target_W, i_Rd_W, i_A1_D, i_A2_D,
        output o_RD1_D, o_RD2_D, o_Result_W, o_WB_Count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 32-entry register file commit with
// same-cycle write-through bypass to the decode read ports, commit counter.
module wb_regfile #(
    parameter int unsigned RD_Data_Width = 32,
    parameter int unsigned PC_Width      = 32,
    parameter int unsigned Address_Width = 5,
    parameter int unsigned Count_Width   = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    localparam int unsigned Depth = 2 ** Address_Width;

    logic [RD_Data_Width-1:0] regs_q [Depth];
    logic [Count_Width-1:0]   wb_count_q;
    logic [RD_Data_Width-1:0] result_c;
    logic                     commit_c;

    // Result select; PC-width sources are zero-extended.
    always_comb begin
        result_c = bus.i_ALU_Res_W;
        case (bus.i_ResultSec_W)
            2'b00:   result_c = bus.i_ALU_Res_W;
            2'b01:   result_c = bus.i_ReadData_W;
            2'b10:   result_c = RD_Data_Width'(bus.i_PCPluse4_W);
            2'b11:   result_c = RD_Data_Width'(bus.i_PC_target_W);
            default: result_c = bus.i_ALU_Res_W;
        endcase
    end

    // A commit only counts when it targets a real register (x0 writes vanish).
    always_comb begin
        commit_c = bus.i_RegWrite_W && (bus.i_Rd_W != '0);
    end

    // Register array: cleared on reset, written on a qualifying commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_c) begin
            regs_q[bus.i_Rd_W] <= result_c;
        end
    end

    // Committed-write counter, wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_q <= '0;
        end else if (commit_c) begin
            wb_count_q <= wb_count_q + Count_Width'(1);
        end
    end

    // Read ports: x0 reads zero, bypass the in-flight commit, else the array.
    always_comb begin
        bus.o_RD1_D = '0;
        bus.o_RD2_D = '0;
        if (rst) begin
            if (bus.i_A1_D == '0) begin
                bus.o_RD1_D = '0;
            end else if (commit_c && (bus.i_A1_D == bus.i_Rd_W)) begin
                bus.o_RD1_D = result_c;
            end else begin
                bus.o_RD1_D = regs_q[bus.i_A1_D];
            end
            if (bus.i_A2_D == '0) begin
                bus.o_RD2_D = '0;
            end else if (commit_c && (bus.i_A2_D == bus.i_Rd_W)) begin
                bus.o_RD2_D = result_c;
            end else begin
                bus.o_RD2_D = regs_q[bus.i_A2_D];
            end
        end
    end

    // Forwarding result is held at zero while reset is asserted.
    always_comb begin
        bus.o_Result_W = rst ? result_c : '0;
        bus.o_WB_Count = wb_count_q;
    end
endmodule
